// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: state
// encoding, default memory timeout and the pipeline control bundle.
package pipe_ctrl_pkg;

    // FSM state encoding (IDLE must be zero so reset lands there)
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_RUN      = 3'd1;
    localparam state_t ST_MEM_WAIT = 3'd2;
    localparam state_t ST_RELEASE  = 3'd3;
    localparam state_t ST_HALT     = 3'd4;

    // MEM_WAIT cycles tolerated without an ack before giving up
    localparam int DEFAULT_TIMEOUT_CYC = 64;

    // Controls applied to the pipeline registers in the current cycle
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic pipe_hold;
    } ctrl_t;

    // Free-running pipeline: PC and IF/ID advance, nothing flushed or held
    function automatic ctrl_t ctrl_run();
        ctrl_t c;
        c.pc_write     = 1'b1;
        c.if_id_write  = 1'b1;
        c.if_id_flush  = 1'b0;
        c.id_ex_bubble = 1'b0;
        c.pipe_hold    = 1'b0;
        return c;
    endfunction

    // Whole pipeline frozen in place
    function automatic ctrl_t ctrl_freeze();
        ctrl_t c;
        c.pc_write     = 1'b0;
        c.if_id_write  = 1'b0;
        c.if_id_flush  = 1'b0;
        c.id_ex_bubble = 1'b0;
        c.pipe_hold    = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/stall_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
module stall_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    // Count enabled cycles, sticking at all-ones once reached
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush responder for the 5-stage pipeline. Arbitrates the
// data-memory freeze, load-use stall and branch flush, drives the pipeline
// register controls, counts stall cycles and flags memory timeouts.
//
// Memory handshake: dmem_start_o is a one-cycle pulse issued in RUN when
// dmem_req_i is high; the memory answers later with a one-cycle dmem_ack_i
// (never in the start cycle). Acks are only honoured in MEM_WAIT.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_CNT_W = 16,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
    parameter int TMO_W       = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   hdu_stall_i,
    input  logic                   branch_taken_i,
    input  logic                   dmem_req_i,
    input  logic                   dmem_ack_i,
    output logic                   pc_write_o,
    output logic                   if_id_write_o,
    output logic                   if_id_flush_o,
    output logic                   id_ex_bubble_o,
    output logic                   pipe_hold_o,
    output logic                   dmem_start_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o,
    output logic                   timeout_o
);

    localparam logic [TMO_W-1:0] WAIT_LAST = TMO_W'(TIMEOUT_CYC - 1);

    state_t           state;
    state_t           state_next;
    ctrl_t            ctrl;
    logic [TMO_W-1:0] wait_cnt;
    logic             wait_clr;
    logic             wait_inc;
    logic             tmo_set;
    logic             stall_en;

    // Mealy arbitration: controls and next state from state plus requests
    always_comb begin
        ctrl         = ctrl_run();
        dmem_start_o = 1'b0;
        state_next   = state;
        wait_clr     = 1'b0;
        wait_inc     = 1'b0;
        tmo_set      = 1'b0;
        case (state)
            ST_IDLE: begin
                ctrl = ctrl_freeze();
                if (start_i) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (dmem_req_i) begin
                    // Memory freeze overrides hazards; they re-evaluate later
                    ctrl         = ctrl_freeze();
                    dmem_start_o = 1'b1;
                    wait_clr     = 1'b1;
                    state_next   = ST_MEM_WAIT;
                end else if (hdu_stall_i) begin
                    // Branch suppressed: it re-resolves with correct operands
                    ctrl.pc_write     = 1'b0;
                    ctrl.if_id_write  = 1'b0;
                    ctrl.id_ex_bubble = 1'b1;
                end else if (branch_taken_i) begin
                    ctrl.if_id_flush = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                ctrl = ctrl_freeze();
                if (dmem_ack_i) begin
                    state_next = ST_RELEASE;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next = ST_HALT;
                    tmo_set    = 1'b1;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            ST_RELEASE: begin
                // dmem_req_i still belongs to the finished access: ignore it
                if (hdu_stall_i) begin
                    ctrl.pc_write     = 1'b0;
                    ctrl.if_id_write  = 1'b0;
                    ctrl.id_ex_bubble = 1'b1;
                end else if (branch_taken_i) begin
                    ctrl.if_id_flush = 1'b1;
                end
                state_next = ST_RUN;
            end
            ST_HALT: begin
                ctrl = ctrl_freeze();
            end
            default: begin
                ctrl       = ctrl_freeze();
                state_next = ST_IDLE;
            end
        endcase
    end

    assign pc_write_o     = ctrl.pc_write;
    assign if_id_write_o  = ctrl.if_id_write;
    assign if_id_flush_o  = ctrl.if_id_flush;
    assign id_ex_bubble_o = ctrl.id_ex_bubble;
    assign pipe_hold_o    = ctrl.pipe_hold;

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // MEM_WAIT cycle counter, cleared when an access is launched
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wait_cnt <= '0;
        end else if (wait_clr) begin
            wait_cnt <= '0;
        end else if (wait_inc) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            timeout_o <= 1'b0;
        end else if (tmo_set) begin
            timeout_o <= 1'b1;
        end
    end

    // Stall cycles are counted only while the pipeline is live
    assign stall_en = ((state == ST_RUN) || (state == ST_MEM_WAIT) ||
                       (state == ST_RELEASE)) && !ctrl.pc_write;

    stall_sat_counter #(
        .W (STALL_CNT_W)
    ) u_stall_cnt (
        .clk   (clk_i),
        .rst_n (rst_i),
        .en    (stall_en),
        .count (stall_cnt_o)
    );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: two instances share all inputs (16-bit and
// 2-bit stall counters, both with a 4-cycle memory timeout) and are checked
// every cycle against a behavioural model of the stall/flush rules.
module tb_pipe_stall_ctrl;

    localparam int TMO = 4;

    // Model modes
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_WAIT = 2;
    localparam int M_REL  = 3;
    localparam int M_HALT = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_i = 1'b0;
    logic start_i = 1'b0, hdu_stall_i = 1'b0, branch_taken_i = 1'b0;
    logic dmem_req_i = 1'b0, dmem_ack_i = 1'b0;

    logic        a_pw, a_iw, a_fl, a_bub, a_hold, a_st, a_tmo;
    logic [15:0] a_cnt;
    logic        b_pw, b_iw, b_fl, b_bub, b_hold, b_st, b_tmo;
    logic [1:0]  b_cnt;

    pipe_stall_ctrl #(.STALL_CNT_W(16), .TIMEOUT_CYC(TMO), .TMO_W(8)) dut_a (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .hdu_stall_i(hdu_stall_i),
        .branch_taken_i(branch_taken_i), .dmem_req_i(dmem_req_i), .dmem_ack_i(dmem_ack_i),
        .pc_write_o(a_pw), .if_id_write_o(a_iw), .if_id_flush_o(a_fl),
        .id_ex_bubble_o(a_bub), .pipe_hold_o(a_hold), .dmem_start_o(a_st),
        .stall_cnt_o(a_cnt), .timeout_o(a_tmo));

    pipe_stall_ctrl #(.STALL_CNT_W(2), .TIMEOUT_CYC(TMO), .TMO_W(8)) dut_b (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .hdu_stall_i(hdu_stall_i),
        .branch_taken_i(branch_taken_i), .dmem_req_i(dmem_req_i), .dmem_ack_i(dmem_ack_i),
        .pc_write_o(b_pw), .if_id_write_o(b_iw), .if_id_flush_o(b_fl),
        .id_ex_bubble_o(b_bub), .pipe_hold_o(b_hold), .dmem_start_o(b_st),
        .stall_cnt_o(b_cnt), .timeout_o(b_tmo));

    // Observation vector: [31:25] ctrl A {pw,iw,flush,bubble,hold,start,tmo},
    // [24:9] count A, [8:2] ctrl B, [1:0] count B
    logic [31:0] obs_now;
    assign obs_now = {a_pw, a_iw, a_fl, a_bub, a_hold, a_st, a_tmo, a_cnt,
                      b_pw, b_iw, b_fl, b_bub, b_hold, b_st, b_tmo, b_cnt};

    logic [31:0] obs, exp_v;
    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    int m_mode, m_waited, m_stalls;
    bit m_tmo;
    bit e_pw, e_iw, e_fl, e_bub, e_hold, e_st;

    task automatic model_reset();
        m_mode = M_IDLE; m_waited = 0; m_stalls = 0; m_tmo = 1'b0;
    endtask

    // Expected controls for the current mode and inputs
    task automatic model_predict();
        e_pw = 1; e_iw = 1; e_fl = 0; e_bub = 0; e_hold = 0; e_st = 0;
        if (m_mode == M_IDLE || m_mode == M_HALT || m_mode == M_WAIT) begin
            e_pw = 0; e_iw = 0; e_hold = 1;
        end else if (m_mode == M_RUN && dmem_req_i) begin
            e_pw = 0; e_iw = 0; e_hold = 1; e_st = 1;
        end else if (hdu_stall_i) begin
            e_pw = 0; e_iw = 0; e_bub = 1;
        end else if (branch_taken_i) begin
            e_fl = 1;
        end
    endtask

    function automatic logic [31:0] pack_exp();
        logic [6:0]  c;
        logic [15:0] sa;
        logic [1:0]  sb;
        c  = {e_pw, e_iw, e_fl, e_bub, e_hold, e_st, m_tmo};
        sa = 16'((m_stalls > 65535) ? 65535 : m_stalls);
        sb = 2'((m_stalls > 3) ? 3 : m_stalls);
        return {c, sa, c, sb};
    endfunction

    // Advance the model across one rising edge
    task automatic model_step();
        if (!e_pw && (m_mode == M_RUN || m_mode == M_WAIT || m_mode == M_REL))
            m_stalls++;
        case (m_mode)
            M_IDLE: if (start_i) m_mode = M_RUN;
            M_RUN:  if (dmem_req_i) begin m_mode = M_WAIT; m_waited = 0; end
            M_WAIT: begin
                if (dmem_ack_i) m_mode = M_REL;
                else begin
                    m_waited++;
                    if (m_waited >= TMO) begin m_mode = M_HALT; m_tmo = 1'b1; end
                end
            end
            M_REL:  m_mode = M_RUN;
            default: ;
        endcase
    endtask

    // ---------------- drivers ----------------
    // Called at a falling edge; snapshots obs/exp_v, returns at next falling edge
    task automatic apply(input bit s, input bit h, input bit b, input bit r, input bit k);
        start_i = s; hdu_stall_i = h; branch_taken_i = b; dmem_req_i = r; dmem_ack_i = k;
        model_predict();
        #1;
        obs   = obs_now;
        exp_v = pack_exp();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // Asserts reset between edges, snapshots, releases at the next falling edge
    task automatic do_reset();
        start_i = 0; hdu_stall_i = 0; branch_taken_i = 0; dmem_req_i = 0; dmem_ack_i = 0;
        rst_i = 1'b0;
        model_reset();
        model_predict();
        #1;
        obs   = obs_now;
        exp_v = pack_exp();
        @(negedge clk);
        rst_i = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        if (obs !== exp_v) begin n_err++; $display("FAIL reset_state obs=%h exp=%h", obs, exp_v); end
        n_vec++;
        apply(1, 0, 0, 0, 0);
        if (obs !== exp_v) begin n_err++; $display("FAIL reset_start_cycle obs=%h exp=%h", obs, exp_v); end
        n_vec++;
        apply(0, 0, 0, 0, 0);
        if (obs !== exp_v) begin n_err++; $display("FAIL reset_run obs=%h exp=%h", obs, exp_v); end
        n_vec++;
        if (obs[31:25] !== 7'b1100000 || obs[24:9] !== 16'd0) begin
            n_err++; $display("FAIL reset_run_const ctrl=%b cnt=%0d need ctrl=1100000 cnt=0", obs[31:25], obs[24:9]);
        end
        n_vec++;
    endtask

    task automatic test_hazard_branch();
        do_reset();
        apply(1, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0);
        apply(0, 1, 1, 0, 0);
        if (obs !== exp_v) begin n_err++; $display("FAIL hazard_cycle obs=%h exp=%h", obs, exp_v); end
        n_vec++;
        if (obs[31:25] !== 7'b0001000) begin
            n_err++; $display("FAIL hazard_const ctrl=%b need 0001000", obs[31:25]);
        end
        n_vec++;
        apply(0, 0, 1, 0, 0);
        if (obs !== exp_v) begin n_err++; $display("FAIL branch_cycle obs=%h exp=%h", obs, exp_v); end
        n_vec++;
        if (obs[31:25] !== 7'b1110000 || obs[24:9] !== 16'd1) begin
            n_err++; $display("FAIL branch_const ctrl=%b cnt=%0d need ctrl=1110000 cnt=1", obs[31:25], obs[24:9]);
        end
        n_vec++;
    endtask

    task automatic test_mem_ack();
        int n_start = 0;
        int n_frz = 0;
        do_reset();
        apply(1, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            apply(0, 0, 0, (i <= 4), (i == 3));
            if (obs !== exp_v) begin n_err++; $display("FAIL mem_ack_cyc%0d obs=%h exp=%h", i, obs, exp_v); end
            n_vec++;
            if (obs[26]) n_start++;
            if (obs[27]) n_frz++;
            if (i == 4 && (obs[31] !== 1'b1 || obs[24:9] !== 16'd4)) begin
                n_err++; $display("FAIL mem_release pw=%b cnt=%0d need pw=1 cnt=4", obs[31], obs[24:9]);
            end
        end
        n_vec++;
        if (n_start != 1 || n_frz != 4) begin
            n_err++; $display("FAIL mem_pulses starts=%0d freezes=%0d need 1 and 4", n_start, n_frz);
        end
        n_vec++;
    endtask

    task automatic test_timeout();
        do_reset();
        apply(1, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0);
        apply(0, 0, 0, 1, 0);
        for (int i = 0; i < 4 + 3; i++) begin
            apply(0, 1, 1, 1, (i >= 4));
            if (obs !== exp_v) begin n_err++; $display("FAIL timeout_cyc%0d obs=%h exp=%h", i, obs, exp_v); end
            n_vec++;
        end
        if (obs[27] !== 1'b1 || obs[25] !== 1'b1 || obs[26] !== 1'b0) begin
            n_err++; $display("FAIL timeout_halt hold=%b tmo=%b start=%b need 1 1 0", obs[27], obs[25], obs[26]);
        end
        n_vec++;
    endtask

    task automatic test_mem_vs_hdu();
        do_reset();
        apply(1, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0);
        apply(0, 1, 0, 1, 0);
        if (obs !== exp_v || obs[28] !== 1'b0 || obs[26] !== 1'b1) begin
            n_err++; $display("FAIL mem_beats_hdu obs=%h exp=%h", obs, exp_v);
        end
        n_vec++;
        apply(0, 1, 0, 1, 1);
        apply(0, 1, 0, 1, 0);
        if (obs !== exp_v || obs[28] !== 1'b1) begin
            n_err++; $display("FAIL release_hdu obs=%h exp=%h bubble=%b need 1", obs, exp_v, obs[28]);
        end
        n_vec++;
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        apply(1, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0);
        apply(0, 0, 0, 1, 0);
        apply(0, 0, 0, 1, 0);
        do_reset();
        if (obs !== exp_v) begin n_err++; $display("FAIL midwait_reset obs=%h exp=%h", obs, exp_v); end
        n_vec++;
        apply(0, 0, 0, 1, 1);
        apply(0, 0, 0, 1, 0);
        if (obs !== exp_v || obs[31:25] !== 7'b0000100 || obs[24:9] !== 16'd0) begin
            n_err++; $display("FAIL midwait_idle obs=%h exp=%h", obs, exp_v);
        end
        n_vec++;
    endtask

    task automatic test_saturation();
        do_reset();
        apply(1, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) apply(0, 1, 0, 0, 0);
        apply(0, 0, 0, 0, 0);
        if (obs !== exp_v || obs[1:0] !== 2'd3 || obs[24:9] !== 16'd5) begin
            n_err++; $display("FAIL saturation cntb=%0d cnta=%0d need 3 and 5", obs[1:0], obs[24:9]);
        end
        n_vec++;
    endtask

    task automatic test_random();
        bit s, h, b, r, k;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if (m_mode == M_HALT && $urandom_range(3, 0) == 0) begin
                do_reset();
                if (obs !== exp_v) begin n_err++; $display("FAIL rand_reset%0d obs=%h exp=%h", i, obs, exp_v); end
                n_vec++;
            end
            s = ($urandom_range(3, 0) == 0);
            h = ($urandom_range(2, 0) == 0);
            b = ($urandom_range(2, 0) == 0);
            r = ($urandom_range(3, 0) == 0);
            if (m_mode == M_WAIT)                k = ($urandom_range(2, 0) == 0);
            else if (m_mode == M_RUN && r)       k = 1'b0;
            else                                 k = ($urandom_range(4, 0) == 0);
            apply(s, h, b, r, k);
            if (obs !== exp_v) begin n_err++; $display("FAIL rand_cyc%0d obs=%h exp=%h", i, obs, exp_v); end
            n_vec++;
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_hazard_branch();
        test_mem_ack();
        test_timeout();
        test_mem_vs_hdu();
        test_reset_mid_wait();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
